// File: rtl/ysyx_25060170_lsu_pkg.sv
// LSU shared definitions.
// Op and size encodings plus the FSM state type.
package ysyx_25060170_lsu_pkg;

    localparam logic [1:0] OP_PASS  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        OUT  = 2'b11
    } state_e;

endpackage

// File: rtl/ysyx_25060170_lsu_align.sv
// LSU lane logic.
// Store replicate/strobe and load lane select/extend.
module ysyx_25060170_lsu_align
    import ysyx_25060170_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store data replication and byte strobes; size 11 acts as word.
    always_comb begin
        st_wdata = wdata;
        st_wstrb = 4'b1111;
        unique case (size)
            SZ_B: begin
                st_wdata = {4{wdata[7:0]}};
                st_wstrb = 4'b0001 << addr_lo;
            end
            SZ_H: begin
                st_wdata = {2{wdata[15:0]}};
                st_wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = wdata;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Load lane select and sign/zero extension.
    always_comb begin
        ld_byte = rdata[7:0];
        unique case (addr_lo)
            2'b00: ld_byte = rdata[7:0];
            2'b01: ld_byte = rdata[15:8];
            2'b10: ld_byte = rdata[23:16];
            2'b11: ld_byte = rdata[31:24];
        endcase
        ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        unique case (size)
            SZ_B:    ld_data = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = {{16{~is_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/ysyx_25060170_lsu.sv
// Load/store unit: one bus transaction at a time, valid/ready to write-back.
// Optional misalign trap: YSYX_25060170_LSU_MISALIGN_CHECK_EN.
module ysyx_25060170_lsu
    import ysyx_25060170_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    state_e            state_q, state_d;
    logic [1:0]        op_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    logic              in_mem;
    logic              misal;
    logic              is_store;
    logic [31:0]       st_wdata;
    logic [3:0]        st_wstrb;
    logic [31:0]       ld_data;

    assign in_mem   = (in_op == OP_LOAD) || (in_op == OP_STORE);
    assign is_store = (op_q == OP_STORE);

`ifdef YSYX_25060170_LSU_MISALIGN_CHECK_EN
    assign misal = in_mem &&
                   (((in_size == SZ_H) && in_addr[0]) ||
                    (in_size[1] && (in_addr[1:0] != 2'b00)));
`else
    assign misal = 1'b0;
`endif

    ysyx_25060170_lsu_align u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .addr_lo     (addr_q[1:0]),
        .wdata       (wdata_q),
        .rdata       (mem_rdata),
        .st_wdata    (st_wdata),
        .st_wstrb    (st_wstrb),
        .ld_data     (ld_data)
    );

    // State register; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = (!in_mem || misal) ? OUT : REQ;
            REQ:  if (mem_gnt) state_d = WAIT;
            WAIT: if (mem_rvalid) state_d = OUT;
            OUT:  if (out_ready) state_d = IDLE;
        endcase
    end

    // Capture the op on accept and the aligned result on response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_PASS;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            op_q    <= in_op;
            size_q  <= in_size;
            uns_q   <= in_unsigned;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            data_q  <= in_addr;
            err_q   <= misal;
        end else if (state_q == WAIT && mem_rvalid) begin
            data_q  <= is_store ? '0 : ld_data;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req && is_store;
    assign mem_addr  = addr_q;
    assign mem_wdata = st_wdata;
    assign mem_wstrb = mem_we ? st_wstrb : 4'b0000;
    assign out_valid = (state_q == OUT);
    assign out_data  = data_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// Directed bench for the load/store unit.
// Inputs driven on falling edges, outputs sampled there too.
module tb_ysyx_25060170_lsu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    ysyx_25060170_lsu dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_size     (in_size),
        .in_unsigned (in_unsigned),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_err     (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one memory op through REQ/WAIT up to the OUT state.
    task automatic mem_op(input string tag, input logic [1:0] op,
                          input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int gdly, input logic [31:0] rdata,
                          input logic [31:0] exp_wd, input logic [3:0] exp_st,
                          input logic [31:0] exp_out, input logic release_out);
        int req_cycles;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        in_op       = op;
        in_size     = sz;
        in_unsigned = uns;
        in_addr     = addr;
        in_wdata    = wd;
        out_ready   = 1'b0;
        step();
        in_valid = 1'b0;
        chk({tag, ".mem_we"}, 32'(mem_we), 32'(op == 2'b10));
        chk({tag, ".mem_addr"}, mem_addr, addr);
        if (op == 2'b10) chk({tag, ".mem_wdata"}, mem_wdata, exp_wd);
        chk({tag, ".mem_wstrb"}, 32'(mem_wstrb), 32'(exp_st));
        req_cycles = 0;
        for (int i = 0; i <= gdly; i++) begin
            if (mem_req) req_cycles++;
            mem_gnt = (i == gdly);
            step();
        end
        mem_gnt = 1'b0;
        chk({tag, ".req_cycles"}, 32'(req_cycles), 32'(gdly + 1));
        chk({tag, ".req_drop"}, 32'(mem_req), 32'd0);
        chk({tag, ".no_valid_wait"}, 32'(out_valid), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        step();
        mem_rvalid = 1'b0;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".out_data"}, out_data, exp_out);
        chk({tag, ".out_err"}, 32'(out_err), 32'd0);
        chk({tag, ".busy"}, 32'(in_ready), 32'd0);
        if (release_out) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk({tag, ".done"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_op       = 2'b00;
        in_size     = 2'b00;
        in_unsigned = 1'b0;
        in_addr     = '0;
        in_wdata    = '0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        out_ready   = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.mem_req", 32'(mem_req), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", out_data, 32'd0);
        chk("rst.out_err", 32'(out_err), 32'd0);
        chk("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rst.release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Pass-through: one cycle of latency, no bus request.
        in_valid  = 1'b1;
        in_op     = 2'b00;
        in_addr   = 32'h1234_5678;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("pass.out_valid", 32'(out_valid), 32'd1);
        chk("pass.out_data", out_data, 32'h1234_5678);
        chk("pass.mem_req", 32'(mem_req), 32'd0);
        chk("pass.in_ready", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b0;
        chk("pass.done", 32'(out_valid), 32'd0);

        // Op 11 behaves like pass-through.
        in_valid = 1'b1;
        in_op    = 2'b11;
        in_addr  = 32'hCAFE_0001;
        step();
        in_valid = 1'b0;
        chk("pass3.out_data", out_data, 32'hCAFE_0001);
        chk("pass3.mem_req", 32'(mem_req), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Byte loads, signed and unsigned, from lane 3.
        mem_op("lbs", 2'b01, 2'b00, 1'b0, 32'h8000_0003, 32'h0, 0,
               32'h80FF_0000, 32'h0, 4'h0, 32'hFFFF_FF80, 1'b1);
        mem_op("lbu", 2'b01, 2'b00, 1'b1, 32'h8000_0003, 32'h0, 0,
               32'h80FF_0000, 32'h0, 4'h0, 32'h0000_0080, 1'b1);

        // Half loads from the upper lane.
        mem_op("lhs", 2'b01, 2'b01, 1'b0, 32'h0000_0022, 32'h0, 1,
               32'h9234_5678, 32'h0, 4'h0, 32'hFFFF_9234, 1'b1);
        mem_op("lhu", 2'b01, 2'b01, 1'b1, 32'h0000_0022, 32'h0, 0,
               32'h9234_5678, 32'h0, 4'h0, 32'h0000_9234, 1'b1);

        // Half store with grant delayed three cycles.
        mem_op("sh", 2'b10, 2'b01, 1'b0, 32'h0000_0010, 32'hAAAA_BEEF, 3,
               32'h0, 32'hBEEF_BEEF, 4'b0011, 32'h0, 1'b1);

        // Byte store to lane 2 and word store.
        mem_op("sb", 2'b10, 2'b00, 1'b0, 32'h0000_0006, 32'h1234_56A5, 0,
               32'h0, 32'hA5A5_A5A5, 4'b0100, 32'h0, 1'b1);
        mem_op("sw", 2'b10, 2'b10, 1'b0, 32'h0000_0008, 32'h0BAD_F00D, 0,
               32'h0, 32'h0BAD_F00D, 4'b1111, 32'h0, 1'b1);

        // Word load held by write-back backpressure.
        mem_op("bp", 2'b01, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 0,
               32'hDEAD_BEEF, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp.hold_valid", 32'(out_valid), 32'd1);
            chk("bp.hold_data", out_data, 32'hDEAD_BEEF);
            chk("bp.hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp.release", 32'(out_valid), 32'd0);

        // Reset while waiting for the response.
        in_valid = 1'b1;
        in_op    = 2'b01;
        in_size  = 2'b10;
        in_addr  = 32'h0000_0040;
        step();
        in_valid = 1'b0;
        mem_gnt  = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("rstw.in_wait", 32'(mem_req), 32'd0);
        rst = 1'b1;
        #1;
        chk("rstw.mem_req", 32'(mem_req), 32'd0);
        chk("rstw.in_ready", 32'(in_ready), 32'd0);
        chk("rstw.out_valid", 32'(out_valid), 32'd0);
        chk("rstw.out_data", out_data, 32'd0);
        chk("rstw.mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        step();
        mem_rvalid = 1'b0;
        chk("rstw.late_rvalid", 32'(out_valid), 32'd0);
        chk("rstw.idle", 32'(in_ready), 32'd1);
        mem_op("after", 2'b01, 2'b10, 1'b0, 32'h0000_0044, 32'h0, 0,
               32'h0123_4567, 32'h0, 4'h0, 32'h0123_4567, 1'b1);

        // Misaligned word load.
`ifdef YSYX_25060170_LSU_MISALIGN_CHECK_EN
        in_valid = 1'b1;
        in_op    = 2'b01;
        in_size  = 2'b10;
        in_addr  = 32'h0000_0002;
        step();
        in_valid = 1'b0;
        chk("mis.mem_req", 32'(mem_req), 32'd0);
        chk("mis.out_valid", 32'(out_valid), 32'd1);
        chk("mis.out_err", 32'(out_err), 32'd1);
        chk("mis.out_data", out_data, 32'h0000_0002);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("mis.done", 32'(out_valid), 32'd0);
`else
        mem_op("mis", 2'b01, 2'b10, 1'b0, 32'h0000_0002, 32'h0, 0,
               32'h89AB_CDEF, 32'h0, 4'h0, 32'h89AB_CDEF, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
